// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a shared single-port memory
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (RPi anti-starvation counter).
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   rpi_req/rpi_we/rpi_addr/rpi_wd  RPi read/write request, held until rpi_ack
//   rpi_ack                         RPi granted this cycle
//   rpi_rvalid/rpi_rd               RPi read data, one cycle after a read ack
//   disp_req/disp_addr              display read request, held until disp_ack
//   disp_ack                        display granted this cycle
//   disp_rvalid/disp_rd             display read data, one cycle after ack
//   mem_addr/mem_wd/mem_we/mem_re   shared memory command
//   mem_rd                          memory read data, one cycle after mem_re
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rpi_req,
  input  logic          rpi_we,
  input  logic [AW-1:0] rpi_addr,
  input  logic [DW-1:0] rpi_wd,
  output logic          rpi_ack,
  output logic          rpi_rvalid,
  output logic [DW-1:0] rpi_rd,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rd
);

  logic starve_force;
  logic rpi_grant;
  logic disp_grant;
  logic rpi_pend;
  logic disp_pend;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Counts cycles the RPi has waited; saturates so the forced win persists
  // until the RPi is actually acked or withdraws.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (rpi_req && !rpi_ack) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign starve_force = (starve_cnt == STARVE_LIM);
`else
  // Strict display priority: the RPi never forces a win (false for any legal STARVE_MAX).
  assign starve_force = (STARVE_MAX < 0);
`endif

  // Display has priority unless the RPi is being forced through.
  assign disp_grant = !reset && disp_req && !(rpi_req && starve_force);
  assign rpi_grant  = !reset && rpi_req && !disp_grant;

  assign rpi_ack  = rpi_grant;
  assign disp_ack = disp_grant;

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (disp_grant) begin
      mem_addr = disp_addr;
      mem_re   = 1'b1;
    end else if (rpi_grant) begin
      mem_addr = rpi_addr;
      mem_wd   = rpi_wd;
      mem_we   = rpi_we;
      mem_re   = !rpi_we;
    end
  end

  // Read-owner tags: remember who issued the read so the returning data is
  // routed to exactly one requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpi_pend  <= 1'b0;
      disp_pend <= 1'b0;
    end else begin
      rpi_pend  <= rpi_grant && !rpi_we;
      disp_pend <= disp_grant;
    end
  end

  // Gate with reset so a read acked just before reset never shows up.
  assign rpi_rvalid  = rpi_pend && !reset;
  assign disp_rvalid = disp_pend && !reset;
  assign rpi_rd      = rpi_rvalid ? mem_rd : '0;
  assign disp_rd     = disp_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int STARVE_MAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rpi_req;
  logic          rpi_we;
  logic [AW-1:0] rpi_addr;
  logic [DW-1:0] rpi_wd;
  logic          rpi_ack;
  logic          rpi_rvalid;
  logic [DW-1:0] rpi_rd;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rd = '0;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .rpi_req(rpi_req), .rpi_we(rpi_we), .rpi_addr(rpi_addr), .rpi_wd(rpi_wd),
    .rpi_ack(rpi_ack), .rpi_rvalid(rpi_rvalid), .rpi_rd(rpi_rd),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rvalid(disp_rvalid), .disp_rd(disp_rd),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0xC0DE0000 | addr.
  logic [DW-1:0] mem_data [256];
  logic [255:0]  mem_valid = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem_data[mem_addr[7:0]]  <= mem_wd;
      mem_valid[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_re) begin
      mem_rd <= mem_valid[mem_addr[7:0]] ? mem_data[mem_addr[7:0]]
                                         : (32'hC0DE_0000 | {24'h0, mem_addr[7:0]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rpi_ack"},     32'(rpi_ack), 32'd0);
    chk({tag, ".disp_ack"},    32'(disp_ack), 32'd0);
    chk({tag, ".mem_we"},      32'(mem_we), 32'd0);
    chk({tag, ".mem_re"},      32'(mem_re), 32'd0);
    chk({tag, ".mem_addr"},    32'(mem_addr), 32'd0);
    chk({tag, ".mem_wd"},      mem_wd, 32'd0);
    chk({tag, ".rpi_rvalid"},  32'(rpi_rvalid), 32'd0);
    chk({tag, ".disp_rvalid"}, 32'(disp_rvalid), 32'd0);
    chk({tag, ".rpi_rd"},      rpi_rd, 32'd0);
    chk({tag, ".disp_rd"},     disp_rd, 32'd0);
  endtask

  initial begin
    bit exp_r;
    reset     = 1'b1;
    rpi_req   = 1'b1;
    rpi_we    = 1'b0;
    rpi_addr  = 16'h0005;
    rpi_wd    = 32'h1111_1111;
    disp_req  = 1'b1;
    disp_addr = 16'h0001;

    // Reset with both requests asserted: everything must stay quiet.
    drive_slot();
    @(negedge clk);
    chk_quiet("reset");
    drive_slot();
    reset    = 1'b0;
    rpi_req  = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    chk_quiet("idle");

    // RPi write 0x0010 <- 0xDEADBEEF, display idle.
    drive_slot();
    rpi_req  = 1'b1;
    rpi_we   = 1'b1;
    rpi_addr = 16'h0010;
    rpi_wd   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr.rpi_ack",  32'(rpi_ack), 32'd1);
    chk("wr.disp_ack", 32'(disp_ack), 32'd0);
    chk("wr.mem_we",   32'(mem_we), 32'd1);
    chk("wr.mem_re",   32'(mem_re), 32'd0);
    chk("wr.mem_addr", 32'(mem_addr), 32'h10);
    chk("wr.mem_wd",   mem_wd, 32'hDEAD_BEEF);
    drive_slot();
    rpi_req = 1'b0;
    rpi_we  = 1'b0;
    @(negedge clk);
    chk("wr.rvalid", 32'(rpi_rvalid), 32'd0);
    chk("wr.rd",     rpi_rd, 32'd0);

    // RPi read 0x0010: ack now, data next cycle.
    drive_slot();
    rpi_req = 1'b1;
    @(negedge clk);
    chk("rd.rpi_ack",  32'(rpi_ack), 32'd1);
    chk("rd.mem_re",   32'(mem_re), 32'd1);
    chk("rd.mem_we",   32'(mem_we), 32'd0);
    chk("rd.rvalid0",  32'(rpi_rvalid), 32'd0);
    drive_slot();
    rpi_req = 1'b0;
    @(negedge clk);
    chk("rd.rvalid1",  32'(rpi_rvalid), 32'd1);
    chk("rd.rd",       rpi_rd, 32'hDEAD_BEEF);
    chk("rd.disp_rv",  32'(disp_rvalid), 32'd0);
    drive_slot();
    @(negedge clk);
    chk("rd.rvalid2",  32'(rpi_rvalid), 32'd0);

    // Display streams 0..3 back to back.
    for (int i = 0; i < 5; i++) begin
      drive_slot();
      disp_req  = (i < 4);
      disp_addr = 16'(i);
      @(negedge clk);
      chk($sformatf("burst%0d.ack", i), 32'(disp_ack), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d.rvalid", i), 32'(disp_rvalid), (i > 0) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d.rd", i), disp_rd, (i > 0) ? (32'hC0DE_0000 | 32'(i - 1)) : 32'd0);
    end
    drive_slot();
    @(negedge clk);
    chk("burst.tail", 32'(disp_rvalid), 32'd0);

    // RPi read then display read: no cross-routing.
    drive_slot();
    rpi_req  = 1'b1;
    rpi_we   = 1'b0;
    rpi_addr = 16'h0010;
    @(negedge clk);
    chk("x.rpi_ack", 32'(rpi_ack), 32'd1);
    drive_slot();
    rpi_req   = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 16'h0002;
    @(negedge clk);
    chk("x.disp_ack",   32'(disp_ack), 32'd1);
    chk("x.rpi_rvalid", 32'(rpi_rvalid), 32'd1);
    chk("x.rpi_rd",     rpi_rd, 32'hDEAD_BEEF);
    chk("x.disp_rv1",   32'(disp_rvalid), 32'd0);
    chk("x.disp_rd1",   disp_rd, 32'd0);
    drive_slot();
    disp_req = 1'b0;
    @(negedge clk);
    chk("x.disp_rv2",   32'(disp_rvalid), 32'd1);
    chk("x.disp_rd2",   disp_rd, 32'hC0DE_0002);
    chk("x.rpi_rv2",    32'(rpi_rvalid), 32'd0);
    chk("x.rpi_rd2",    rpi_rd, 32'd0);

    // Both requesting continuously.
    drive_slot();
    rpi_req   = 1'b1;
    rpi_we    = 1'b0;
    rpi_addr  = 16'h0010;
    disp_req  = 1'b1;
    disp_addr = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) drive_slot();
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_r = (i == STARVE_MAX);
`else
      exp_r = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("starve%0d.rpi_ack", i), 32'(rpi_ack), 32'(exp_r));
      chk($sformatf("starve%0d.disp_ack", i), 32'(disp_ack), 32'(!exp_r));
    end

    // Display read acked, then reset: the read must never surface.
    drive_slot();
    rpi_req   = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 16'h0003;
    @(negedge clk);
    chk("rst.disp_ack", 32'(disp_ack), 32'd1);
    drive_slot();
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("rst.mid");
    drive_slot();
    reset    = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    chk_quiet("rst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
